// File: rtl/image_stream_proc.sv
// image_stream_proc: streaming RGB point processor for a WIDTH x HEIGHT frame.
//   Each frame runs V_sync start-up, then for every row an H blanking gap followed by
//   WIDTH/PIX_PER_CLK accepted beats. Every accepted beat is transformed by the mode
//   latched at start and appears one cycle later on m_data/m_valid.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             frame start pulse, honoured only while idle
//   mode              00 bypass, 01 brightness, 10 grey inversion, 11 threshold
//   bright_sub        brightness direction: 0 add, 1 subtract
//   value, threshold  brightness offset and threshold level
//   s_valid, s_ready  input beat handshake
//   s_data            PIX_PER_CLK pixels, pixel k channel c (R,G,B) at [(3k+c)*DW +: DW]
//   V_sync            high during start-up delay
//   H_sync, m_valid   high for each output beat
//   m_data            processed beat, same packing as s_data; holds when m_valid is low
//   frame_done        one-cycle pulse after the last output beat of a frame
module image_stream_proc #(
    parameter int unsigned WIDTH          = 768,
    parameter int unsigned HEIGHT         = 512,
    parameter int unsigned PIX_PER_CLK    = 2,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned START_UP_DELAY = 100,
    parameter int unsigned H_SYNC_DELAY   = 150
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [1:0]                            mode,
    input  logic                                  bright_sub,
    input  logic [DATA_WIDTH-1:0]                 value,
    input  logic [DATA_WIDTH-1:0]                 threshold,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [PIX_PER_CLK*3*DATA_WIDTH-1:0]   s_data,
    output logic                                  V_sync,
    output logic                                  H_sync,
    output logic                                  m_valid,
    output logic [PIX_PER_CLK*3*DATA_WIDTH-1:0]   m_data,
    output logic                                  frame_done
);

    localparam int unsigned BW   = PIX_PER_CLK * 3 * DATA_WIDTH;
    localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned MAXD = (START_UP_DELAY > H_SYNC_DELAY) ? START_UP_DELAY : H_SYNC_DELAY;
    localparam int unsigned NW   = $clog2(MAXD + 1);
    // Two guard bits so channel sums (up to 3*MAXV) never overflow.
    localparam int unsigned AW   = DATA_WIDTH + 2;

    localparam logic [AW-1:0] MAXV     = AW'((2 ** DATA_WIDTH) - 1);
    localparam logic [NW-1:0] VS_LAST  = NW'(START_UP_DELAY - 1);
    localparam logic [NW-1:0] HS_LAST  = NW'(H_SYNC_DELAY - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - PIX_PER_CLK);
    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

    typedef enum logic [2:0] {StIdle, StVsync, StHsync, StData, StDone} state_e;

    state_e          state_q, state_d;
    logic [NW-1:0]   cnt_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    logic [1:0]      mode_q;
    logic            sub_q;
    logic [AW-1:0]   val_q, thr_q;
    logic            accept;
    logic            valid_q, done_q;
    logic [BW-1:0]   data_q, proc_data;
    logic [AW-1:0]   chan [3];
    logic [AW-1:0]   grey;
    logic [DATA_WIDTH-1:0] res;

    assign accept = s_valid & s_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StVsync;
            StVsync: if (cnt_q == VS_LAST) state_d = StHsync;
            StHsync: if (cnt_q == HS_LAST) state_d = StData;
            StData:  if (accept && col_q == LAST_COL) state_d = (row_q == LAST_ROW) ? StDone : StHsync;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        V_sync  = (state_q == StVsync);
        s_ready = (state_q == StData);
    end

    // Delay counter restarts on every state change, so each timed state starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q == StVsync || state_q == StHsync) && state_d == state_q) begin
            cnt_q <= cnt_q + NW'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    // Pixel position and frame configuration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            mode_q <= '0;
            sub_q  <= 1'b0;
            val_q  <= '0;
            thr_q  <= '0;
        end else if (state_q == StIdle) begin
            col_q <= '0;
            row_q <= '0;
            if (start) begin
                mode_q <= mode;
                sub_q  <= bright_sub;
                val_q  <= AW'(value);
                thr_q  <= AW'(threshold);
            end
        end else if (accept) begin
            if (col_q == LAST_COL) begin
                col_q <= '0;
                row_q <= row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(PIX_PER_CLK);
            end
        end
    end

    // Point operation on the incoming beat
    always_comb begin
        proc_data = '0;
        chan      = '{default: '0};
        grey      = '0;
        res       = '0;
        for (int k = 0; k < int'(PIX_PER_CLK); k++) begin
            for (int c = 0; c < 3; c++) begin
                chan[c] = AW'(s_data[(3*k+c)*DATA_WIDTH +: DATA_WIDTH]);
            end
            grey = (chan[0] + chan[1] + chan[2]) / AW'(3);
            for (int c = 0; c < 3; c++) begin
                case (mode_q)
                    2'b00: res = DATA_WIDTH'(chan[c]);
                    2'b01: begin
                        if (sub_q) begin
                            res = (chan[c] > val_q) ? DATA_WIDTH'(chan[c] - val_q) : '0;
                        end else begin
                            res = (chan[c] + val_q > MAXV) ? DATA_WIDTH'(MAXV)
                                                           : DATA_WIDTH'(chan[c] + val_q);
                        end
                    end
                    2'b10:   res = DATA_WIDTH'(MAXV - grey);
                    default: res = (grey > thr_q) ? DATA_WIDTH'(MAXV) : '0;
                endcase
                proc_data[(3*k+c)*DATA_WIDTH +: DATA_WIDTH] = res;
            end
        end
    end

    // Output stage: one cycle latency, data holds between beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= accept;
            done_q  <= (state_q == StDone);
            if (accept) data_q <= proc_data;
        end
    end

    assign m_valid    = valid_q;
    assign H_sync     = valid_q;
    assign m_data     = data_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_image_stream_proc.sv
// Randomized self-checking bench for image_stream_proc on a small 8x2 frame.
module tb_image_stream_proc;

    localparam int W     = 8;
    localparam int H     = 2;
    localparam int PPC   = 2;
    localparam int DWD   = 8;
    localparam int SUD   = 4;
    localparam int HSD   = 3;
    localparam int BW    = PPC * 3 * DWD;
    localparam int BEATS = W / PPC;
    localparam int MAXV  = (1 << DWD) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = '0;
    logic          bright_sub = 1'b0;
    logic [7:0]    value = '0;
    logic [7:0]    threshold = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [BW-1:0] s_data = '0;
    logic          V_sync, H_sync, m_valid, frame_done;
    logic [BW-1:0] m_data;

    int            n_checks = 0;
    int            n_bad = 0;
    logic          pend = 1'b0;
    logic [BW-1:0] pend_data = '0;
    logic [BW-1:0] hold_data = '0;

    image_stream_proc #(
        .WIDTH(W), .HEIGHT(H), .PIX_PER_CLK(PPC), .DATA_WIDTH(DWD),
        .START_UP_DELAY(SUD), .H_SYNC_DELAY(HSD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bright_sub(bright_sub),
        .value(value), .threshold(threshold), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .V_sync(V_sync), .H_sync(H_sync), .m_valid(m_valid),
        .m_data(m_data), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] pk(input int r0, input int g0, input int b0,
                                         input int r1, input int g1, input int b1);
        return {8'(b1), 8'(g1), 8'(r1), 8'(b0), 8'(g0), 8'(r0)};
    endfunction

    // Reference: the point operations written directly as integer arithmetic.
    function automatic logic [BW-1:0] model(input logic [1:0] md, input logic sb,
                                            input logic [7:0] v, input logic [7:0] th,
                                            input logic [BW-1:0] din);
        logic [BW-1:0] out;
        int ch [3];
        int grey, o;
        out = '0;
        for (int k = 0; k < PPC; k++) begin
            for (int c = 0; c < 3; c++) ch[c] = int'(din[(3*k+c)*DWD +: DWD]);
            grey = (ch[0] + ch[1] + ch[2]) / 3;
            for (int c = 0; c < 3; c++) begin
                case (md)
                    2'b00: o = ch[c];
                    2'b01: begin
                        if (sb) o = (ch[c] - int'(v) < 0) ? 0 : ch[c] - int'(v);
                        else    o = (ch[c] + int'(v) > MAXV) ? MAXV : ch[c] + int'(v);
                    end
                    2'b10:   o = MAXV - grey;
                    default: o = (grey > int'(th)) ? MAXV : 0;
                endcase
                out[(3*k+c)*DWD +: DWD] = 8'(o);
            end
        end
        return out;
    endfunction

    task automatic run_frame(input logic [1:0] md, input logic sb, input logic [7:0] v,
                             input logic [7:0] th, input int valid_pct, input logic use_pre,
                             input logic [BW-1:0] pre, input logic [BW-1:0] exp_first,
                             input int rst_at);
        int   vs_len = 0, gap = 0, row_beats = 0, rows = 0, total = 0;
        logic prev_vs = 1'b0, prev_ready = 1'b0, prev_mv = 1'b0;
        logic vs_done = 1'b0, done = 1'b0, first_out;
        first_out = use_pre;
        @(negedge clk);
        mode = md; bright_sub = sb; value = v; threshold = th; start = 1'b1; s_valid = 1'b0;
        s_data = use_pre ? pre : BW'({$urandom, $urandom});
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            check_eq("m_valid", 64'(m_valid), 64'(pend));
            check_eq("h_sync", 64'(H_sync), 64'(pend));
            if (pend) hold_data = pend_data;
            check_eq("m_data", 64'(m_data), 64'(hold_data));
            if (pend && first_out) begin
                check_eq("first_beat", 64'(m_data), 64'(exp_first));
                first_out = 1'b0;
            end
            if (V_sync) vs_len++;
            if (prev_vs && !V_sync) begin
                check_eq("vsync_len", 64'(vs_len), 64'(SUD));
                vs_done = 1'b1;
            end
            if (s_ready && !prev_ready) begin
                check_eq("hsync_gap", 64'(gap), 64'(HSD));
                gap = 0;
                row_beats = 0;
            end
            if (!s_ready && prev_ready) begin
                check_eq("row_beats", 64'(row_beats), 64'(BEATS));
                rows++;
            end
            if (vs_done && !V_sync && !s_ready) gap++;
            if (frame_done) begin
                check_eq("done_after_last", 64'(prev_mv), 64'(1));
                check_eq("frame_beats", 64'(total), 64'(BEATS * H));
                check_eq("frame_rows", 64'(rows), 64'(H));
                done = 1'b1;
                break;
            end
            prev_vs = V_sync; prev_ready = s_ready; prev_mv = m_valid;
            if (rst_at > 0 && total == rst_at) begin
                rst = 1'b1; start = 1'b0; s_valid = 1'b0;
                #1;
                check_eq("rst_outputs", 64'({V_sync, H_sync, m_valid, frame_done, s_ready}), 64'(0));
                check_eq("rst_m_data", 64'(m_data), 64'(0));
                pend = 1'b0;
                hold_data = '0;
                @(negedge clk);
                rst = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check_eq("idle_after_rst", 64'({frame_done, V_sync, s_ready, m_valid}), 64'(0));
                end
                return;
            end
            // Config inputs and start wander mid-frame; the DUT must ignore them.
            start      = ($urandom_range(0, 3) == 0);
            mode       = 2'($urandom);
            bright_sub = 1'($urandom);
            value      = 8'($urandom);
            threshold  = 8'($urandom);
            s_valid    = ($urandom_range(1, 100) <= valid_pct);
            if (!(use_pre && total == 0)) s_data = BW'({$urandom, $urandom});
            if (s_valid && s_ready) begin
                pend = 1'b1;
                pend_data = model(md, sb, v, th, s_data);
                row_beats++;
                total++;
            end else begin
                pend = 1'b0;
            end
        end
        if (!done) check_eq("frame_timeout", 64'(0), 64'(1));
        start = 1'b0;
        s_valid = 1'b0;
        pend = 1'b0;
        @(negedge clk);
        check_eq("idle_after_done", 64'({frame_done, V_sync, s_ready, m_valid}), 64'(0));
    endtask

    initial begin
        logic [1:0] rmd;
        logic       rsb;
        logic [7:0] rv, rth;
        repeat (3) @(negedge clk);
        check_eq("reset_ctrl", 64'({V_sync, H_sync, m_valid, frame_done, s_ready}), 64'(0));
        check_eq("reset_data", 64'(m_data), 64'(0));
        rst = 1'b0;

        run_frame(2'b01, 1'b0, 8'd100, 8'd0, 100, 1'b1,
                  pk(200, 100, 0, 155, 156, 255), pk(255, 200, 100, 255, 255, 255), 0);
        run_frame(2'b01, 1'b1, 8'd100, 8'd0, 100, 1'b1,
                  pk(50, 100, 230, 50, 100, 230), pk(0, 0, 130, 0, 0, 130), 0);
        run_frame(2'b10, 1'b0, 8'd0, 8'd0, 100, 1'b1,
                  pk(30, 60, 90, 30, 60, 90), pk(195, 195, 195, 195, 195, 195), 0);
        run_frame(2'b11, 1'b0, 8'd0, 8'd90, 100, 1'b1,
                  pk(90, 90, 90, 91, 91, 91), pk(0, 0, 0, 255, 255, 255), 0);
        run_frame(2'b00, 1'b0, 8'd0, 8'd0, 60, 1'b0, '0, '0, 0);
        run_frame(2'b01, 1'b0, 8'd37, 8'd0, 100, 1'b0, '0, '0, BEATS + 2);
        for (int i = 0; i < 8; i++) begin
            rmd = 2'($urandom); rsb = 1'($urandom); rv = 8'($urandom); rth = 8'($urandom);
            run_frame(rmd, rsb, rv, rth, 70, 1'b0, '0, '0, 0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_checks, n_bad);
        $fatal(1);
    end

endmodule
